// File: rtl/axi4_lite_pkg.sv
// Shared types and constants for the AXI4-Lite command master.
package axi4_lite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic [2:0] {
        IDLE,
        WR_AW_W,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        RSP
    } mst_state_t;

    // Only these data widths are supported by the master.
    localparam int DW_NARROW = 32;
    localparam int DW_WIDE   = 64;

    function automatic bit dw_supported(input int w);
        return (w == DW_NARROW) || (w == DW_WIDE);
    endfunction

endpackage

// File: rtl/axi4_lite_valid_hold.sv
// Registered VALID flag: sets on load, clears the cycle after its handshake.
module axi4_lite_valid_hold (
    input  logic ACLK,
    input  logic ARESETN,
    input  logic load,
    input  logic ready,
    output logic valid
);

    // Load wins over clear; a handshake only clears an asserted flag.
    always_ff @(posedge ACLK) begin
        if (!ARESETN)
            valid <= 1'b0;
        else if (load)
            valid <= 1'b1;
        else if (valid && ready)
            valid <= 1'b0;
    end

endmodule

// File: rtl/axi4_lite_master_cmd.sv
// AXI4-Lite master: one single-beat read or write per command, with the
// slave's data/response returned on a valid/ready response channel.
module axi4_lite_master_cmd
    import axi4_lite_pkg::*;
#(
    parameter  int ADDR_WIDTH    = 32,
    parameter  int DATA_WIDTH    = 32,
    parameter  int ERR_CNT_WIDTH = 8,
    localparam int STRB_WIDTH    = DATA_WIDTH / 8
) (
    input  logic                     ACLK,
    input  logic                     ARESETN,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_write,
    input  logic [ADDR_WIDTH-1:0]    cmd_addr,
    input  logic [DATA_WIDTH-1:0]    cmd_wdata,
    input  logic [STRB_WIDTH-1:0]    cmd_wstrb,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic                     rsp_write,
    output logic [DATA_WIDTH-1:0]    rsp_rdata,
    output logic [1:0]               rsp_resp,
    output logic [ERR_CNT_WIDTH-1:0] err_count,
    output logic                     busy,
    output logic [ADDR_WIDTH-1:0]    M_AWADDR,
    output logic                     M_AWVALID,
    input  logic                     M_AWREADY,
    output logic [DATA_WIDTH-1:0]    M_WDATA,
    output logic [STRB_WIDTH-1:0]    M_WSTRB,
    output logic                     M_WVALID,
    input  logic                     M_WREADY,
    input  logic [1:0]               M_BRESP,
    input  logic                     M_BVALID,
    output logic                     M_BREADY,
    output logic [ADDR_WIDTH-1:0]    M_ARADDR,
    output logic                     M_ARVALID,
    input  logic                     M_ARREADY,
    input  logic [DATA_WIDTH-1:0]    M_RDATA,
    input  logic [1:0]               M_RRESP,
    input  logic                     M_RVALID,
    output logic                     M_RREADY
);

    generate
        if (!dw_supported(DATA_WIDTH)) begin : g_bad_dw
            $error("axi4_lite_master_cmd: DATA_WIDTH must be 32 or 64");
        end
    endgenerate

    mst_state_t state, state_nxt;

    logic [ADDR_WIDTH-1:0]    addr_q;
    logic [DATA_WIDTH-1:0]    wdata_q;
    logic [STRB_WIDTH-1:0]    wstrb_q;
    logic                     rsp_write_q;
    logic [DATA_WIDTH-1:0]    rsp_rdata_q;
    resp_t                    rsp_resp_q;
    logic [ERR_CNT_WIDTH-1:0] err_q;
    logic                     bready_q, rready_q;

    logic  cmd_fire, b_fire, r_fire, aw_done, w_done;
    resp_t cap_resp;

    assign cmd_fire = cmd_valid && cmd_ready;
    // READY is only ever high in its own state, so stray VALIDs never fire.
    assign b_fire   = M_BVALID && bready_q;
    assign r_fire   = M_RVALID && rready_q;
    // A channel is done once its flag has dropped or is handshaking now.
    assign aw_done  = !M_AWVALID || M_AWREADY;
    assign w_done   = !M_WVALID  || M_WREADY;
    assign cap_resp = b_fire ? resp_t'(M_BRESP) : resp_t'(M_RRESP);

    axi4_lite_valid_hold u_aw (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .load(cmd_fire && cmd_write), .ready(M_AWREADY), .valid(M_AWVALID)
    );
    axi4_lite_valid_hold u_w (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .load(cmd_fire && cmd_write), .ready(M_WREADY), .valid(M_WVALID)
    );
    axi4_lite_valid_hold u_ar (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .load(cmd_fire && !cmd_write), .ready(M_ARREADY), .valid(M_ARVALID)
    );

    // State register.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_fire)          state_nxt = cmd_write ? WR_AW_W : RD_ADDR;
            WR_AW_W: if (aw_done && w_done) state_nxt = WR_RESP;
            WR_RESP: if (b_fire)            state_nxt = RSP;
            RD_ADDR: if (M_ARREADY)         state_nxt = RD_DATA;
            RD_DATA: if (r_fire)            state_nxt = RSP;
            RSP:     if (rsp_ready)         state_nxt = IDLE;
            default:                        state_nxt = IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        cmd_ready = (state == IDLE);
        busy      = (state != IDLE);
        rsp_valid = (state == RSP);
    end

    // Response-channel READYs are registered off the next state so they track it exactly.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            bready_q <= 1'b0;
            rready_q <= 1'b0;
        end else begin
            bready_q <= (state_nxt == WR_RESP);
            rready_q <= (state_nxt == RD_DATA);
        end
    end

    // Command payload, held stable for the whole transaction.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else if (cmd_fire) begin
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
            wstrb_q <= cmd_wstrb;
        end
    end

    // Capture B or R into the response register; writes return zero data.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= OKAY;
        end else if (b_fire) begin
            rsp_write_q <= 1'b1;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= resp_t'(M_BRESP);
        end else if (r_fire) begin
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= M_RDATA;
            rsp_resp_q  <= resp_t'(M_RRESP);
        end
    end

    // Saturating count of non-OKAY responses.
    always_ff @(posedge ACLK) begin
        if (!ARESETN)
            err_q <= '0;
        else if ((b_fire || r_fire) && (cap_resp != OKAY) && (err_q != '1))
            err_q <= err_q + ERR_CNT_WIDTH'(1);
    end

    assign M_AWADDR  = addr_q;
    assign M_ARADDR  = addr_q;
    assign M_WDATA   = wdata_q;
    assign M_WSTRB   = wstrb_q;
    assign M_BREADY  = bready_q;
    assign M_RREADY  = rready_q;
    assign rsp_write = rsp_write_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_resp  = rsp_resp_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_axi4_lite_master_cmd.sv
// Directed bench for axi4_lite_master_cmd (32-bit and 64-bit instances).
module tb_axi4_lite_master_cmd;

    logic ACLK, ARESETN;

    // 32-bit instance signals
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [7:0]  err_count;
    logic        busy;
    logic [31:0] M_AWADDR, M_WDATA, M_ARADDR, M_RDATA;
    logic [3:0]  M_WSTRB;
    logic        M_AWVALID, M_AWREADY, M_WVALID, M_WREADY, M_BVALID, M_BREADY;
    logic        M_ARVALID, M_ARREADY, M_RVALID, M_RREADY;
    logic [1:0]  M_BRESP, M_RRESP;

    // 64-bit instance signals
    logic        x_cmd_valid, x_cmd_ready, x_cmd_write;
    logic [31:0] x_cmd_addr;
    logic [63:0] x_cmd_wdata;
    logic [7:0]  x_cmd_wstrb;
    logic        x_rsp_valid, x_rsp_ready, x_rsp_write;
    logic [63:0] x_rsp_rdata;
    logic [1:0]  x_rsp_resp;
    logic [7:0]  x_err_count;
    logic        x_busy;
    logic [31:0] x_AWADDR, x_ARADDR;
    logic [63:0] x_WDATA, x_RDATA;
    logic [7:0]  x_WSTRB;
    logic        x_AWVALID, x_AWREADY, x_WVALID, x_WREADY, x_BVALID, x_BREADY;
    logic        x_ARVALID, x_ARREADY, x_RVALID, x_RREADY;
    logic [1:0]  x_BRESP, x_RRESP;

    axi4_lite_master_cmd #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ERR_CNT_WIDTH(8)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .err_count(err_count), .busy(busy),
        .M_AWADDR(M_AWADDR), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
        .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
        .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY),
        .M_ARADDR(M_ARADDR), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
        .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RVALID(M_RVALID), .M_RREADY(M_RREADY)
    );

    axi4_lite_master_cmd #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .ERR_CNT_WIDTH(8)) dut64 (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .cmd_valid(x_cmd_valid), .cmd_ready(x_cmd_ready), .cmd_write(x_cmd_write),
        .cmd_addr(x_cmd_addr), .cmd_wdata(x_cmd_wdata), .cmd_wstrb(x_cmd_wstrb),
        .rsp_valid(x_rsp_valid), .rsp_ready(x_rsp_ready), .rsp_write(x_rsp_write),
        .rsp_rdata(x_rsp_rdata), .rsp_resp(x_rsp_resp), .err_count(x_err_count), .busy(x_busy),
        .M_AWADDR(x_AWADDR), .M_AWVALID(x_AWVALID), .M_AWREADY(x_AWREADY),
        .M_WDATA(x_WDATA), .M_WSTRB(x_WSTRB), .M_WVALID(x_WVALID), .M_WREADY(x_WREADY),
        .M_BRESP(x_BRESP), .M_BVALID(x_BVALID), .M_BREADY(x_BREADY),
        .M_ARADDR(x_ARADDR), .M_ARVALID(x_ARVALID), .M_ARREADY(x_ARREADY),
        .M_RDATA(x_RDATA), .M_RRESP(x_RRESP), .M_RVALID(x_RVALID), .M_RREADY(x_RREADY)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          aw_dly, w_dly, ar_dly;
        logic [1:0]  resp;
        logic [31:0] rdata;      // driven on M_RDATA (garbage for writes)
        int          exp_lat;    // negedges after accept until rsp_valid
        logic [31:0] exp_rdata;
        logic [7:0]  exp_err;
    } vec_t;

    vec_t vt[5];

    // Called at a negedge: present a command and let it be accepted.
    task automatic drive_cmd(input vec_t v);
        chk("cmd_ready_idle", cmd_ready, 1'b1);
        cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata; cmd_wstrb = v.strb;
        cmd_valid = 1'b1;
        @(posedge ACLK);
        @(negedge ACLK);
        cmd_valid = 1'b0;
    endtask

    // Called at the first negedge after accept: act as slave, check the
    // protocol and the response, hold rsp_ready low for 'hold' cycles.
    task automatic service(input vec_t v, input int hold);
        bit aw_hs = 0, w_hs = 0, ar_hs = 0, b_hs = 0, r_hs = 0, viol = 0, done = 0;
        bit f_aw, f_w, f_ar, f_b, f_r;
        int aw_n = 0, w_n = 0, ar_n = 0, k = 0;
        int n_aw = 0, n_w = 0, n_ar = 0, n_b = 0, n_r = 0;
        logic [31:0] s_d; logic [1:0] s_r; logic s_w;
        rsp_ready = 1'b0;
        while (!done && k < 60) begin
            k++;
            if (rsp_valid) done = 1;
            else begin
                if (M_BREADY && (!(aw_hs && w_hs) || b_hs)) viol = 1;
                if (M_RREADY && (!ar_hs || r_hs))           viol = 1;
                if (M_AWVALID && aw_hs) viol = 1;
                if (M_WVALID  && w_hs)  viol = 1;
                if (M_ARVALID && ar_hs) viol = 1;
                if (v.wr && ((!aw_hs && !M_AWVALID) || (!w_hs && !M_WVALID) || M_ARVALID)) viol = 1;
                if (!v.wr && ((!ar_hs && !M_ARVALID) || M_AWVALID || M_WVALID)) viol = 1;
                if (M_AWVALID && M_AWADDR !== v.addr) viol = 1;
                if (M_WVALID && (M_WDATA !== v.wdata || M_WSTRB !== v.strb)) viol = 1;
                if (M_ARVALID && M_ARADDR !== v.addr) viol = 1;
                M_AWREADY = M_AWVALID && (aw_n >= v.aw_dly);
                M_WREADY  = M_WVALID  && (w_n  >= v.w_dly);
                M_ARREADY = M_ARVALID && (ar_n >= v.ar_dly);
                M_BVALID  = aw_hs && w_hs && !b_hs;
                M_BRESP   = v.resp;
                M_RVALID  = ar_hs && !r_hs;
                M_RDATA   = v.rdata;
                M_RRESP   = v.resp;
                f_aw = M_AWVALID && M_AWREADY;
                f_w  = M_WVALID  && M_WREADY;
                f_ar = M_ARVALID && M_ARREADY;
                f_b  = M_BVALID  && M_BREADY;
                f_r  = M_RVALID  && M_RREADY;
                if (M_AWVALID && !f_aw) aw_n++;
                if (M_WVALID  && !f_w)  w_n++;
                if (M_ARVALID && !f_ar) ar_n++;
                @(posedge ACLK);
                aw_hs |= f_aw; w_hs |= f_w; ar_hs |= f_ar; b_hs |= f_b; r_hs |= f_r;
                n_aw += int'(f_aw); n_w += int'(f_w); n_ar += int'(f_ar);
                n_b  += int'(f_b);  n_r += int'(f_r);
                @(negedge ACLK);
                M_AWREADY = 0; M_WREADY = 0; M_ARREADY = 0; M_BVALID = 0; M_RVALID = 0;
            end
        end
        chk("latency", 64'(k), 64'(v.exp_lat));
        chk("protocol_ok", viol, 1'b0);
        chk("n_addr_hs", 64'(v.wr ? n_aw : n_ar), 64'd1);
        chk("n_data_hs", 64'(v.wr ? n_w : 0), 64'(v.wr ? 1 : 0));
        chk("n_resp_hs", 64'(v.wr ? n_b : n_r), 64'd1);
        chk("rsp_write", rsp_write, v.wr);
        chk("rsp_rdata", rsp_rdata, v.exp_rdata);
        chk("rsp_resp", rsp_resp, v.resp);
        chk("err_count", err_count, v.exp_err);
        chk("busy_rsp", busy, 1'b1);
        s_d = rsp_rdata; s_r = rsp_resp; s_w = rsp_write;
        for (int h = 0; h < hold; h++) begin
            @(posedge ACLK);
            @(negedge ACLK);
            chk("hold_rsp_valid", rsp_valid, 1'b1);
            chk("hold_cmd_ready", cmd_ready, 1'b0);
            chk("hold_payload", {s_w, s_r, rsp_rdata}, {rsp_write, rsp_resp, s_d});
        end
        rsp_ready = 1'b1;
        @(posedge ACLK);
        @(negedge ACLK);
        rsp_ready = 1'b0;
        chk("rsp_valid_drop", rsp_valid, 1'b0);
    endtask

    initial begin
        vec_t v;
        int e;
        vt[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 2'd0, 32'hFFFF_FFFF, 3, 32'h0, 8'd0};
        vt[1] = '{1'b1, 32'h0000_0014, 32'hCAFE_F00D, 4'h3, 0, 3, 0, 2'd0, 32'hFFFF_FFFF, 6, 32'h0, 8'd0};
        vt[2] = '{1'b0, 32'h0000_0020, 32'h0,         4'h0, 0, 0, 2, 2'd2, 32'h1234_5678, 5, 32'h1234_5678, 8'd1};
        vt[3] = '{1'b1, 32'h0000_0018, 32'h0000_0055, 4'h1, 2, 0, 0, 2'd1, 32'h5555_AAAA, 5, 32'h0, 8'd2};
        vt[4] = '{1'b0, 32'h0000_0033, 32'h0,         4'h0, 0, 0, 0, 2'd0, 32'hA5A5_5A5A, 3, 32'hA5A5_5A5A, 8'd2};

        ARESETN = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
        rsp_ready = 0; M_AWREADY = 0; M_WREADY = 0; M_BRESP = 0; M_BVALID = 0;
        M_ARREADY = 0; M_RDATA = 0; M_RRESP = 0; M_RVALID = 0;
        x_cmd_valid = 0; x_cmd_write = 0; x_cmd_addr = 0; x_cmd_wdata = 0; x_cmd_wstrb = 0;
        x_rsp_ready = 0; x_AWREADY = 1; x_WREADY = 1; x_BRESP = 0; x_BVALID = 0;
        x_ARREADY = 1; x_RDATA = 0; x_RRESP = 0; x_RVALID = 0;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        chk("rst_valids", {M_AWVALID, M_WVALID, M_ARVALID, M_BREADY, M_RREADY, rsp_valid}, 6'b0);
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_err", err_count, 8'd0);
        chk("rst_payload", {M_AWADDR, M_WDATA, M_WSTRB, rsp_rdata, rsp_resp, rsp_write}, 0);
        chk("rst64_valids", {x_AWVALID, x_WVALID, x_ARVALID, x_BREADY, x_RREADY, x_rsp_valid}, 6'b0);
        ARESETN = 1;

        // Unsolicited B/R with error codes while idle: ignored.
        M_BVALID = 1; M_RVALID = 1; M_BRESP = 2'd3; M_RRESP = 2'd3;
        @(posedge ACLK);
        @(negedge ACLK);
        M_BVALID = 0; M_RVALID = 0;
        chk("unsol_err", err_count, 8'd0);
        chk("unsol_state", {rsp_valid, busy, cmd_ready}, 3'b001);

        foreach (vt[i]) begin
            drive_cmd(vt[i]);
            service(vt[i], 0);
        end

        // Response backpressure with a pending command.
        v = '{1'b0, 32'h0000_0024, 32'h0, 4'h0, 0, 0, 0, 2'd0, 32'h0BAD_CAFE, 3, 32'h0BAD_CAFE, 8'd2};
        drive_cmd(v);
        cmd_valid = 1'b1;
        service(v, 5);
        chk("bp_cmd_ready_after", cmd_ready, 1'b1);
        @(posedge ACLK);
        @(negedge ACLK);
        cmd_valid = 1'b0;
        chk("bp_next_accepted", {busy, M_ARVALID}, 2'b11);
        service(v, 0);

        // Error counter saturation with DECERR reads.
        for (int i = 0; i < 260; i++) begin
            e = (i + 3 > 255) ? 255 : i + 3;
            v = '{1'b0, 32'h100 + 32'(i * 4), 32'h0, 4'h0, 0, 0, 0, 2'd3, 32'(i), 3, 32'(i), 8'(e)};
            drive_cmd(v);
            service(v, 0);
        end
        chk("err_saturated", err_count, 8'd255);

        // Reset while waiting for B.
        drive_cmd(vt[0]);
        M_AWREADY = 1; M_WREADY = 1;
        @(posedge ACLK);
        @(negedge ACLK);
        M_AWREADY = 0; M_WREADY = 0;
        chk("wr_resp_bready", {M_BREADY, M_AWVALID, M_WVALID}, 3'b100);
        ARESETN = 0;
        @(posedge ACLK);
        @(negedge ACLK);
        ARESETN = 1;
        chk("mid_rst_valids", {M_AWVALID, M_WVALID, M_ARVALID, M_BREADY, M_RREADY, rsp_valid}, 6'b0);
        chk("mid_rst_idle", {cmd_ready, busy}, 2'b10);
        chk("mid_rst_err", err_count, 8'd0);
        @(posedge ACLK);
        @(negedge ACLK);
        chk("mid_rst_no_rsp", rsp_valid, 1'b0);

        // 64-bit write, slave always ready.
        x_cmd_write = 1; x_cmd_addr = 32'h40; x_cmd_wdata = 64'h0123_4567_89AB_CDEF;
        x_cmd_wstrb = 8'h0F; x_cmd_valid = 1;
        @(posedge ACLK);
        @(negedge ACLK);
        x_cmd_valid = 0;
        chk("w64_aw_w_valid", {x_AWVALID, x_WVALID}, 2'b11);
        chk("w64_awaddr", x_AWADDR, 32'h40);
        chk("w64_wdata", x_WDATA, 64'h0123_4567_89AB_CDEF);
        chk("w64_wstrb", x_WSTRB, 8'h0F);
        @(posedge ACLK);
        @(negedge ACLK);
        chk("w64_bready", {x_BREADY, x_AWVALID, x_WVALID}, 3'b100);
        x_BVALID = 1;
        @(posedge ACLK);
        @(negedge ACLK);
        x_BVALID = 0;
        chk("w64_rsp", {x_rsp_valid, x_rsp_write, x_rsp_resp, x_BREADY}, 5'b11000);
        chk("w64_rdata", x_rsp_rdata, 64'h0);
        chk("w64_err", x_err_count, 8'd0);
        x_rsp_ready = 1;
        @(posedge ACLK);
        @(negedge ACLK);
        x_rsp_ready = 0;
        chk("w64_idle", {x_rsp_valid, x_cmd_ready}, 2'b01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/axi4_lite_master_cmd.md
Name: axi4_lite_master_cmd

Overview:
Parametrised AXI4-Lite master driven by a valid/ready command interface; issues one single-beat read or write per command and returns the slave's data and response on a valid/ready response interface.
Generalises the fixed-32-bit IDLE/ADDR/DATA master:
- AW and W are issued concurrently.
- Byte strobes come from the caller.
- The B/R response is captured and returned.
- Non-OKAY responses are counted.
Sits between a local controller (register sequencer, CPU bridge) and an AXI4-Lite interconnect.

Parameters:
ADDR_WIDTH, 32, width of cmd_addr, M_AWADDR, M_ARADDR
DATA_WIDTH, 32, data width; 32 or 64 only (elaboration-time check); STRB_WIDTH = DATA_WIDTH/8
ERR_CNT_WIDTH, 8, width of saturating error counter

Ports:
ACLK  in  1  clock, all logic rising-edge
ARESETN  in  1  synchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when valid&ready
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_WIDTH  byte address
cmd_wdata  in  DATA_WIDTH  write data
cmd_wstrb  in  STRB_WIDTH  write byte strobes
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed when valid&ready
rsp_write  out  1  response belongs to a write
rsp_rdata  out  DATA_WIDTH  read data (0 for writes)
rsp_resp  out  2  BRESP/RRESP captured
err_count  out  ERR_CNT_WIDTH  saturating count of non-OKAY responses
busy  out  1  state != IDLE
M_AWADDR, M_AWVALID, M_AWREADY, M_WDATA, M_WSTRB, M_WVALID, M_WREADY, M_BRESP, M_BVALID, M_BREADY, M_ARADDR, M_ARVALID, M_ARREADY, M_RDATA, M_RRESP, M_RVALID, M_RREADY: standard AXI4-Lite master-side directions; widths ADDR_WIDTH/DATA_WIDTH/STRB_WIDTH/2/1 as applicable

Behaviour:
- Reset (ARESETN=0 at a rising edge): state=IDLE. All M_*VALID, M_BREADY, M_RREADY, rsp_valid = 0. Address/data/strb/rsp registers = 0; err_count=0. Reset mid-transaction abandons the transaction with no response.
- States: IDLE, WR_AW_W, WR_RESP, RD_ADDR, RD_DATA, RSP.
- cmd_ready = (state==IDLE), combinational from state only.
- IDLE:
  - On cmd_valid&cmd_ready, latch addr/wdata/wstrb. Address is used as given (no alignment forcing).
  - Write: M_AWVALID=M_WVALID=1 from next cycle, go WR_AW_W.
  - Read: M_ARVALID=1 from next cycle, go RD_ADDR.
- WR_AW_W:
  - AWVALID and WVALID are independent registered flags; each clears in the cycle after its own handshake.
  - AW and W may complete in the same cycle or in either order.
  - Leave for WR_RESP once both have completed (the edge where the last one completes).
  - VALIDs never drop before their handshake; payload stable while VALID.
- WR_RESP: M_BREADY=1 (registered); on M_BVALID capture BRESP, rsp_write=1, rsp_rdata=0, go RSP. BREADY deasserts the next cycle.
- RD_ADDR: M_ARVALID held until M_ARREADY, then go RD_DATA.
- RD_DATA: M_RREADY=1; on M_RVALID capture RDATA/RRESP, rsp_write=0, go RSP.
- RSP: rsp_valid=1 with stable payload until rsp_ready; then go IDLE and rsp_valid=0 next cycle. No new command is accepted in RSP.
- err_count increments by 1 at each response capture with resp!=2'b00; saturates at all-ones and never wraps.
- Minimum latency, slaves always ready: command accept edge T; AW/W handshake T+1; B handshake T+2; rsp_valid T+3. Read is identical: AR T+1, R T+2, rsp T+3.
- M_BREADY is never high outside WR_RESP; M_RREADY is never high outside RD_DATA.
- Unsolicited M_BVALID/M_RVALID in other states is ignored.

Decomposition:
- Package axi4_lite_pkg holds:
  - resp_t enum: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
  - master state enum.
  - Supported DATA_WIDTH check constants.
- One natural sub-module, axi4_lite_valid_hold: a registered VALID that sets on load and clears on handshake. Instantiated for AW, W and AR.

Test Plan:
- Write 0x0000_0010 data 0xDEAD_BEEF strb 0xF, slave always ready, BRESP=OKAY → AW/W at T+1 with matching payload; rsp_valid at T+3 with rsp_write=1, rsp_resp=0; err_count=0.
- Write where M_WREADY arrives 3 cycles after M_AWREADY → AWVALID drops after its handshake; WVALID held 3 extra cycles; BREADY only after the W handshake; one response.
- Read 0x0000_0020, ARREADY delayed 2 cycles, RDATA=0x1234_5678, RRESP=SLVERR → rsp_rdata=0x1234_5678, rsp_resp=2, err_count=1.
- rsp_ready held low 5 cycles with cmd_valid high → rsp payload stable; cmd_ready=0 throughout; next command accepted the cycle after rsp handshake.
- 260 consecutive DECERR reads (ERR_CNT_WIDTH=8) → err_count saturates at 255.
- ARESETN low during WR_RESP → next cycle all VALID/READY=0, state IDLE, cmd_ready=1, no rsp_valid; also rerun the write scenario at DATA_WIDTH=64 with strb 0x0F.
